sng_array: RTL and testbench

//  Multi-channel stochastic number generator: loads NUM_CH binary values per handshake and

---
 rtl/sng_array.sv | 156 +++++++++++++++
 tb/tb_sng_array.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sng_array.sv
// sng_array: multi-channel stochastic number generator.
// Loads NUM_CH binary values per valid/ready handshake and emits NUM_CH parallel
// unipolar bitstreams of STREAM_LEN bits, framed by out_valid/out_last. Every
// channel owns a private Fibonacci LFSR with a distinct seed.
// Optional build macro SNG_ARRAY_BIPOLAR_EN: inputs are two's complement and are
// converted to offset binary when latched (MSB inverted).
module sng_array #(
  parameter int PRECISION  = 8,
  parameter int NUM_CH     = 4,
  parameter int STREAM_LEN = 255,
  parameter int SEED_BASE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*PRECISION-1:0]   in_data,
  output logic [NUM_CH-1:0]             out_bits,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          busy
);

  localparam int CW = $clog2(STREAM_LEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Maximal-length feedback taps (XAPP052), as a bit mask over the LFSR.
  function automatic logic [PRECISION-1:0] tap_mask();
    logic [15:0] m;
    case (PRECISION)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h00B8;
    endcase
    return m[PRECISION-1:0];
  endfunction

  localparam logic [PRECISION-1:0] TAPS = tap_mask();

`ifdef SNG_ARRAY_BIPOLAR_EN
  localparam logic [PRECISION-1:0] VAL_FLIP = {1'b1, {(PRECISION-1){1'b0}}};
`else
  localparam logic [PRECISION-1:0] VAL_FLIP = '0;
`endif

  // Channel seed: SEED_BASE+k truncated to PRECISION bits; zero would lock the LFSR.
  function automatic logic [PRECISION-1:0] seed_of(input int unsigned k);
    int                   t;
    logic [PRECISION-1:0] s;
    t = SEED_BASE + int'(k);
    s = t[PRECISION-1:0];
    if (s == '0) s = {{(PRECISION-1){1'b0}}, 1'b1};
    return s;
  endfunction

  function automatic logic [PRECISION-1:0] lfsr_step(input logic [PRECISION-1:0] x);
    return {x[PRECISION-2:0], ^(x & TAPS)};
  endfunction

  state_t                             state, state_nxt;
  logic [CW-1:0]                      cnt;
  logic [NUM_CH-1:0][PRECISION-1:0]   lfsr;
  logic [NUM_CH-1:0][PRECISION-1:0]   val;
  logic [NUM_CH-1:0][PRECISION-1:0]   in_val;
  logic [NUM_CH-1:0]                  cmp;
  logic                               cnt_last;
  logic                               xfer;

  assign cnt_last = (cnt == CW'(STREAM_LEN - 1));
  assign xfer     = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a transfer always lands in RUN; a finished stream without one drops to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = RUN;
      RUN:     if (cnt_last && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state and counter.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        in_ready = cnt_last;
        busy     = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Per-channel input slicing with optional offset-binary conversion.
  always_comb begin
    in_val = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      in_val[k] = in_data[k*PRECISION +: PRECISION] ^ VAL_FLIP;
  end

  // Stochastic comparison: bit is 1 when the LFSR sample does not exceed the value.
  always_comb begin
    cmp = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      cmp[k] = (lfsr[k] <= val[k]);
  end

  // Datapath: value latch, LFSRs, stream counter and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      val       <= '0;
      out_bits  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++)
        lfsr[k] <= seed_of(k);
    end else begin
      out_bits  <= (state == RUN) ? cmp : '0;
      out_valid <= (state == RUN);
      out_last  <= (state == RUN) && cnt_last;
      if (xfer) begin
        val <= in_val;
        cnt <= '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
          lfsr[k] <= seed_of(k);
      end else if (state == RUN) begin
        // Hold the counter at zero once the stream ends so it never passes STREAM_LEN-1.
        cnt <= cnt_last ? '0 : cnt + 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++)
          lfsr[k] <= lfsr_step(lfsr[k]);
      end
    end
  end

endmodule

// File: tb/tb_sng_array.sv
// Directed bench for sng_array: reset, stream framing and ones counts, gapless
// back-to-back loading, ignored mid-stream requests, seed decorrelation, and a
// STREAM_LEN=1 instance.
module tb_sng_array;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  out_bits;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] in_data1;
  logic [1:0]  out_bits1;
  logic        out_valid1;
  logic        out_last1;
  logic        busy1;

  int vectors     = 0;
  int miscompares = 0;

  // tally results
  int           nv, nl, runs, first_j, last_vidx, stray;
  int           cnt [4];
  logic [254:0] seq [4];
  logic         rdy_at_pulse;

  sng_array #(.PRECISION(8), .NUM_CH(4), .STREAM_LEN(255), .SEED_BASE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_bits(out_bits), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  sng_array #(.PRECISION(8), .NUM_CH(2), .STREAM_LEN(1), .SEED_BASE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_bits(out_bits1), .out_valid(out_valid1), .out_last(out_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  // Observe ncyc edges; optionally raise in_valid with pdata for one edge at cycle pulse_j.
  task automatic tally(input int ncyc, input int pulse_j, input logic [31:0] pdata);
    logic prev;
    prev = 1'b0;
    nv = 0; nl = 0; runs = 0; first_j = -1; last_vidx = -1; stray = 0;
    rdy_at_pulse = 1'b1;
    for (int k = 0; k < 4; k++) begin cnt[k] = 0; seq[k] = '0; end
    for (int j = 0; j < ncyc; j++) begin
      if (j == pulse_j) begin
        rdy_at_pulse = in_ready;
        in_valid = 1'b1;
        in_data  = pdata;
      end
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        if (!prev) runs++;
        if (first_j < 0) first_j = j;
        for (int k = 0; k < 4; k++) begin
          if (out_bits[k]) cnt[k]++;
          if (nv < 255) seq[k][nv] = out_bits[k];
        end
        if (out_last) begin nl++; last_vidx = nv; end
        nv++;
      end else if (out_bits != 4'b0 || out_last) begin
        stray++;
      end
      prev = out_valid;
    end
  endtask

  initial begin
    int   xf, tnv, truns;
    int   cs [2][4];
    logic tprev;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bits",  out_bits,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_busy",      busy,      0);
    rst = 1'b0;
    tick();

`ifndef SNG_ARRAY_BIPOLAR_EN
    // Basic stream: ch3..ch0 = 255,128,1,0
    check("t2_ready_before", in_ready, 1);
    load({8'd255, 8'd128, 8'd1, 8'd0});
    check("t2_busy",        busy,      1);
    check("t2_not_ready",   in_ready,  0);
    check("t2_no_valid_yet", out_valid, 0);
    tick();
    check("t2_first_valid", out_valid, 1);
    check("t2_first_bits",  out_bits,  4'b1100);
    tally(300, -1, '0);
    check("t2_nvalid",   nv + 1, 255);
    check("t2_runs",     runs, 1);
    check("t2_lasts",    nl, 1);
    check("t2_last_pos", last_vidx + 1, 254);
    check("t2_stray",    stray, 0);
    check("t2_idle_busy",  busy, 0);
    check("t2_idle_ready", in_ready, 1);

    // Full framing count from the transfer edge
    load({8'd255, 8'd128, 8'd1, 8'd0});
    tally(300, -1, '0);
    check("t2_first_j",  first_j, 0);
    check("t2_nv",       nv, 255);
    check("t2_ch3",      cnt[3], 255);
    check("t2_ch2",      cnt[2], 128);
    check("t2_ch1",      cnt[1], 1);
    check("t2_ch0",      cnt[0], 0);
    check("t2_lastidx",  last_vidx, 254);

    // Back-to-back streams with in_valid held high
    in_valid = 1'b1; in_data = {8'd64, 8'd32, 8'd16, 8'd8};
    xf = 0; tnv = 0; truns = 0; tprev = 1'b0;
    for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) cs[s][k] = 0;
    for (int j = 0; j < 700; j++) begin
      if (in_valid && in_ready) xf++;
      tick();
      if (xf == 1) in_data = {8'd200, 8'd100, 8'd50, 8'd3};
      else if (xf >= 2) in_valid = 1'b0;
      if (out_valid) begin
        if (!tprev) truns++;
        for (int k = 0; k < 4; k++) if (out_bits[k]) cs[(tnv < 255) ? 0 : 1][k]++;
        tnv++;
      end
      tprev = out_valid;
    end
    in_valid = 1'b0;
    check("t3_transfers", xf, 2);
    check("t3_nvalid",    tnv, 510);
    check("t3_runs",      truns, 1);
    check("t3_s0_ch0", cs[0][0], 8);
    check("t3_s0_ch3", cs[0][3], 64);
    check("t3_s1_ch0", cs[1][0], 3);
    check("t3_s1_ch1", cs[1][1], 50);
    check("t3_s1_ch2", cs[1][2], 100);
    check("t3_s1_ch3", cs[1][3], 200);

    // Mid-stream request at cnt=10 is ignored
    load({8'd255, 8'd128, 8'd1, 8'd0});
    tally(300, 10, {8'd0, 8'd0, 8'd0, 8'd255});
    check("t4_ready_at_pulse", rdy_at_pulse, 0);
    check("t4_nv",   nv, 255);
    check("t4_runs", runs, 1);
    check("t4_ch3",  cnt[3], 255);
    check("t4_ch2",  cnt[2], 128);
    check("t4_ch1",  cnt[1], 1);
    check("t4_ch0",  cnt[0], 0);

    // Distinct seeds decorrelate equal values
    load({8'd0, 8'd128, 8'd128, 8'd0});
    tally(300, -1, '0);
    check("t5_ch1", cnt[1], 128);
    check("t5_ch2", cnt[2], 128);
    check("t5_differ", (seq[1] !== seq[2]), 1);
`else
    // Bipolar: ch0=00, ch1=80, ch2=7F, ch3=00
    load({8'h00, 8'h7F, 8'h80, 8'h00});
    tally(300, -1, '0);
    check("t6_first_j", first_j, 0);
    check("t6_nv",  nv, 255);
    check("t6_ch0", cnt[0], 128);
    check("t6_ch1", cnt[1], 0);
    check("t6_ch2", cnt[2], 255);
    check("t6_ch3", cnt[3], 128);
    check("t6_first_bits", {seq[3][0], seq[2][0], seq[1][0], seq[0][0]}, 4'b1101);
`endif

    // STREAM_LEN=1 instance: one bit per transfer, ready stays high in RUN
    in_valid1 = 1'b1; in_data1 = {8'd1, 8'd1};
    tick();
    in_valid1 = 1'b0;
    check("t7_busy",  busy1, 1);
    check("t7_ready", in_ready1, 1);
    tick();
    check("t7_valid", out_valid1, 1);
    check("t7_last",  out_last1, 1);
`ifndef SNG_ARRAY_BIPOLAR_EN
    check("t7_bits",  out_bits1, 2'b01);
`else
    check("t7_bits",  out_bits1, 2'b11);
`endif
    check("t7_idle",  busy1, 0);
    tick();
    check("t7_valid_off", out_valid1, 0);
    check("t7_bits_off",  out_bits1, 0);

    // Reset mid-stream aborts it
    load({8'd255, 8'd128, 8'd1, 8'd0});
    tally(20, -1, '0);
    check("t1_pre_nv", nv, 20);
    rst = 1'b1;
    tick();
    check("t1_out_valid", out_valid, 0);
    check("t1_out_bits",  out_bits,  0);
    check("t1_out_last",  out_last,  0);
    check("t1_in_ready",  in_ready,  1);
    check("t1_busy",      busy,      0);
    tick();
    rst = 1'b0;
    tally(300, -1, '0);
    check("t1_no_stale_valid", nv, 0);
    check("t1_no_stale_bits",  stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
